alu_issue_stage: RTL and testbench

- ID→EX issue stage for the RV32IM pipeline. Decodes a fetched instruction into the 6-bit ALU operation code, operand-source selects, immediate and side-band controls.
- Registers the result toward the execute stage through a 2-entry skid buffer with valid/ready handshakes on both sides.
- Acts as the producer side of the ALU SELECT/operand interface.

---
 rtl/alu_ops_pkg.sv | 45 ++++
 rtl/rv32im_alu_decoder.sv | 133 +++++++++++++
 rtl/alu_issue_stage.sv | 97 +++++++++
 tb/tb_alu_issue_stage.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_ops_pkg.sv
// Shared ALU SELECT codes, RV32 opcodes and the decoded payload
// carried from the issue stage toward execute.
package alu_ops_pkg;

    localparam logic [5:0] ALU_ADD  = 6'b000000;
    localparam logic [5:0] ALU_SLL  = 6'b000001;
    localparam logic [5:0] ALU_SLT  = 6'b000010;
    localparam logic [5:0] ALU_SLTU = 6'b000011;
    localparam logic [5:0] ALU_XOR  = 6'b000100;
    localparam logic [5:0] ALU_SRL  = 6'b000101;
    localparam logic [5:0] ALU_OR   = 6'b000110;
    localparam logic [5:0] ALU_AND  = 6'b000111;
    localparam logic [5:0] ALU_MUL  = 6'b001000;
    localparam logic [5:0] ALU_SUB  = 6'b010000;
    localparam logic [5:0] ALU_SRA  = 6'b010101;
    localparam logic [5:0] ALU_FWD  = 6'b011000;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef struct packed {
        logic [5:0]  alu_select;
        logic        op1_sel;
        logic        op2_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } dec_payload_t;

endpackage

// File: rtl/rv32im_alu_decoder.sv
// Combinational RV32IM decode of one instruction word into the ALU payload.
module rv32im_alu_decoder
    import alu_ops_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0]  inst,
    output dec_payload_t dec
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_sh = {27'b0, inst[24:20]};

    always_comb begin
        dec        = '0;
        dec.rs1    = inst[19:15];
        dec.rs2    = inst[24:20];
        dec.rd     = inst[11:7];
        dec.funct3 = f3;
        case (opcode)
            OPC_OP: begin
                dec.reg_write = 1'b1;
                case (f7)
                    7'b0000000: dec.alu_select = {3'b000, f3};
                    7'b0100000: begin
                        if (f3 == 3'b000 || f3 == 3'b101) dec.alu_select = {3'b010, f3};
                        else                               dec.illegal    = 1'b1;
                    end
                    7'b0000001: begin
                        if (ENABLE_M) dec.alu_select = {3'b001, f3};
                        else          dec.illegal    = 1'b1;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.op2_sel   = 1'b1;
                dec.imm       = imm_i;
                case (f3)
                    3'b001: begin
                        dec.imm = imm_sh;
                        if (f7 == 7'b0000000) dec.alu_select = ALU_SLL;
                        else                  dec.illegal    = 1'b1;
                    end
                    3'b101: begin
                        dec.imm = imm_sh;
                        if (f7 == 7'b0000000)      dec.alu_select = ALU_SRL;
                        else if (f7 == 7'b0100000) dec.alu_select = ALU_SRA;
                        else                       dec.illegal    = 1'b1;
                    end
                    default: dec.alu_select = {3'b000, f3};
                endcase
            end
            OPC_LUI: begin
                dec.alu_select = ALU_FWD;
                dec.op2_sel    = 1'b1;
                dec.imm        = imm_u;
                dec.reg_write  = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alu_select = ALU_ADD;
                dec.op1_sel    = 1'b1;
                dec.op2_sel    = 1'b1;
                dec.imm        = imm_u;
                dec.reg_write  = 1'b1;
            end
            OPC_JAL: begin
                dec.alu_select = ALU_ADD;
                dec.op1_sel    = 1'b1;
                dec.op2_sel    = 1'b1;
                dec.imm        = imm_j;
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
            end
            OPC_JALR: begin
                dec.alu_select = ALU_ADD;
                dec.op2_sel    = 1'b1;
                dec.imm        = imm_i;
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.illegal    = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.imm    = imm_b;
                dec.branch = 1'b1;
                case (f3)
                    3'b000, 3'b001: dec.alu_select = ALU_SUB;
                    3'b100, 3'b101: dec.alu_select = ALU_SLT;
                    3'b110, 3'b111: dec.alu_select = ALU_SLTU;
                    default:        dec.illegal    = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.alu_select = ALU_ADD;
                dec.op2_sel    = 1'b1;
                dec.imm        = imm_i;
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
            end
            OPC_STORE: begin
                dec.alu_select = ALU_ADD;
                dec.op2_sel    = 1'b1;
                dec.imm        = imm_s;
                dec.mem_write  = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        // Illegal words still flow downstream, but must not cause side effects.
        if (dec.illegal) begin
            dec.alu_select = ALU_ADD;
            dec.reg_write  = 1'b0;
            dec.mem_read   = 1'b0;
            dec.mem_write  = 1'b0;
            dec.branch     = 1'b0;
            dec.jump       = 1'b0;
        end
        if (dec.rd == 5'd0) dec.reg_write = 1'b0;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes the incoming word and hands it to execute
// through a 2-entry skid buffer (main entry drives outputs, skid absorbs one stall).
module alu_issue_stage
    import alu_ops_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit ENABLE_M   = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  FLUSH,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [DATA_WIDTH-1:0] INSTRUCTION,
    input  logic [DATA_WIDTH-1:0] PC_IN,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [5:0]            ALU_SELECT,
    output logic                  OP1_SEL,
    output logic                  OP2_SEL,
    output logic [DATA_WIDTH-1:0] IMMEDIATE,
    output logic [4:0]            RS1_ADDR,
    output logic [4:0]            RS2_ADDR,
    output logic [4:0]            RD_ADDR,
    output logic [2:0]            FUNCT3,
    output logic                  REG_WRITE,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic                  BRANCH,
    output logic                  JUMP,
    output logic                  ILLEGAL,
    output logic [DATA_WIDTH-1:0] PC_OUT
);

    typedef struct packed {
        dec_payload_t          pl;
        logic [DATA_WIDTH-1:0] pc;
    } entry_t;

    dec_payload_t dec;
    entry_t       in_entry, main_q, skid_q;
    logic         main_vld, skid_vld;
    logic         accept, drain;

    rv32im_alu_decoder #(.ENABLE_M(ENABLE_M)) u_dec (
        .inst (INSTRUCTION),
        .dec  (dec)
    );

    assign in_entry = '{pl: dec, pc: PC_IN};
    assign IN_READY = !skid_vld;
    assign accept   = IN_VALID && IN_READY;
    assign drain    = main_vld && OUT_READY;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (FLUSH) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!main_vld || drain) begin
            // Skid is only ever occupied behind a valid main, so it refills main first.
            if (skid_vld) begin
                main_q   <= skid_q;
                main_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                main_vld <= accept;
                if (accept) main_q <= in_entry;
            end
        end else if (accept) begin
            skid_q   <= in_entry;
            skid_vld <= 1'b1;
        end
    end

    assign OUT_VALID  = main_vld;
    assign ALU_SELECT = main_q.pl.alu_select;
    assign OP1_SEL    = main_q.pl.op1_sel;
    assign OP2_SEL    = main_q.pl.op2_sel;
    assign IMMEDIATE  = main_q.pl.imm;
    assign RS1_ADDR   = main_q.pl.rs1;
    assign RS2_ADDR   = main_q.pl.rs2;
    assign RD_ADDR    = main_q.pl.rd;
    assign FUNCT3     = main_q.pl.funct3;
    assign REG_WRITE  = main_q.pl.reg_write;
    assign MEM_READ   = main_q.pl.mem_read;
    assign MEM_WRITE  = main_q.pl.mem_write;
    assign BRANCH     = main_q.pl.branch;
    assign JUMP       = main_q.pl.jump;
    assign ILLEGAL    = main_q.pl.illegal;
    assign PC_OUT     = main_q.pc;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, skid ordering, flush and reset.
module tb_alu_issue_stage;

    logic        CLK = 1'b0;
    logic        RESET, FLUSH, IN_VALID, OUT_READY;
    logic [31:0] INSTRUCTION, PC_IN;

    logic        IN_READY, OUT_VALID, OP1_SEL, OP2_SEL;
    logic [5:0]  ALU_SELECT;
    logic [31:0] IMMEDIATE, PC_OUT;
    logic [4:0]  RS1_ADDR, RS2_ADDR, RD_ADDR;
    logic [2:0]  FUNCT3;
    logic        REG_WRITE, MEM_READ, MEM_WRITE, BRANCH, JUMP, ILLEGAL;

    logic        nm_in_ready, nm_out_valid, nm_op1, nm_op2;
    logic [5:0]  nm_sel;
    logic [31:0] nm_imm, nm_pc;
    logic [4:0]  nm_rs1, nm_rs2, nm_rd;
    logic [2:0]  nm_f3;
    logic        nm_rw, nm_mr, nm_mw, nm_br, nm_jmp, nm_ill;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    alu_issue_stage #(.DATA_WIDTH(32), .ENABLE_M(1'b1)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .INSTRUCTION(INSTRUCTION), .PC_IN(PC_IN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .ALU_SELECT(ALU_SELECT), .OP1_SEL(OP1_SEL), .OP2_SEL(OP2_SEL), .IMMEDIATE(IMMEDIATE),
        .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR), .RD_ADDR(RD_ADDR), .FUNCT3(FUNCT3),
        .REG_WRITE(REG_WRITE), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .BRANCH(BRANCH),
        .JUMP(JUMP), .ILLEGAL(ILLEGAL), .PC_OUT(PC_OUT)
    );

    alu_issue_stage #(.DATA_WIDTH(32), .ENABLE_M(1'b0)) dut_nm (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(nm_in_ready),
        .INSTRUCTION(INSTRUCTION), .PC_IN(PC_IN), .OUT_VALID(nm_out_valid), .OUT_READY(OUT_READY),
        .ALU_SELECT(nm_sel), .OP1_SEL(nm_op1), .OP2_SEL(nm_op2), .IMMEDIATE(nm_imm),
        .RS1_ADDR(nm_rs1), .RS2_ADDR(nm_rs2), .RD_ADDR(nm_rd), .FUNCT3(nm_f3),
        .REG_WRITE(nm_rw), .MEM_READ(nm_mr), .MEM_WRITE(nm_mw), .BRANCH(nm_br),
        .JUMP(nm_jmp), .ILLEGAL(nm_ill), .PC_OUT(nm_pc)
    );

    // Present one word for a single cycle; returns at the negedge after capture.
    task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
        @(negedge CLK);
        IN_VALID = 1'b1; INSTRUCTION = inst; PC_IN = pc;
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; FLUSH = 1'b0; OUT_READY = 1'b1;
        IN_VALID = 1'b1; INSTRUCTION = 32'h002081B3; PC_IN = 32'h40;
        repeat (2) @(negedge CLK);
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", OUT_VALID); end
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", IN_READY); end
        checks++; if ({ALU_SELECT, RD_ADDR, RS1_ADDR, REG_WRITE} !== 17'd0) begin errors++; $display("FAIL reset_payload: sel=%b rd=%0d rs1=%0d rw=%0b want 0", ALU_SELECT, RD_ADDR, RS1_ADDR, REG_WRITE); end
        checks++; if (PC_OUT !== 32'h0 || IMMEDIATE !== 32'h0) begin errors++; $display("FAIL reset_pc_imm: pc=%h imm=%h want 0", PC_OUT, IMMEDIATE); end
        RESET = 1'b0; IN_VALID = 1'b0;
        @(negedge CLK);
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_release_idle: got %0b want 0", OUT_VALID); end
    endtask

    task automatic test_add();
        OUT_READY = 1'b1;
        issue(32'h002081B3, 32'h100);
        checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL add_valid: got %0b want 1", OUT_VALID); end
        checks++; if (ALU_SELECT !== 6'b000000 || OP2_SEL !== 1'b0 || REG_WRITE !== 1'b1) begin errors++; $display("FAIL add_ctrl: sel=%b op2=%0b rw=%0b want 000000/0/1", ALU_SELECT, OP2_SEL, REG_WRITE); end
        checks++; if (RS1_ADDR !== 5'd1 || RS2_ADDR !== 5'd2 || RD_ADDR !== 5'd3) begin errors++; $display("FAIL add_regs: rs1=%0d rs2=%0d rd=%0d want 1/2/3", RS1_ADDR, RS2_ADDR, RD_ADDR); end
        checks++; if (PC_OUT !== 32'h100 || ILLEGAL !== 1'b0) begin errors++; $display("FAIL add_pc: pc=%h ill=%0b want 100/0", PC_OUT, ILLEGAL); end
        @(negedge CLK);
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL add_drained: got %0b want 0", OUT_VALID); end
    endtask

    task automatic test_decode();
        OUT_READY = 1'b1;
        issue(32'h40335293, 32'h104);  // srai x5,x6,3
        checks++; if (ALU_SELECT !== 6'b010101 || OP2_SEL !== 1'b1 || IMMEDIATE !== 32'h3) begin errors++; $display("FAIL srai: sel=%b op2=%0b imm=%h want 010101/1/3", ALU_SELECT, OP2_SEL, IMMEDIATE); end
        checks++; if (RD_ADDR !== 5'd5 || RS1_ADDR !== 5'd6 || REG_WRITE !== 1'b1) begin errors++; $display("FAIL srai_regs: rd=%0d rs1=%0d rw=%0b want 5/6/1", RD_ADDR, RS1_ADDR, REG_WRITE); end
        issue(32'h123453B7, 32'h108);  // lui x7,0x12345
        checks++; if (ALU_SELECT !== 6'b011000 || IMMEDIATE !== 32'h12345000 || RD_ADDR !== 5'd7) begin errors++; $display("FAIL lui: sel=%b imm=%h rd=%0d want 011000/12345000/7", ALU_SELECT, IMMEDIATE, RD_ADDR); end
        issue(32'h02C5C533, 32'h10C);  // div x10,x11,x12
        checks++; if (ALU_SELECT !== 6'b001100 || ILLEGAL !== 1'b0 || REG_WRITE !== 1'b1) begin errors++; $display("FAIL div_m: sel=%b ill=%0b rw=%0b want 001100/0/1", ALU_SELECT, ILLEGAL, REG_WRITE); end
        checks++; if (nm_out_valid !== 1'b1 || nm_ill !== 1'b1 || nm_rw !== 1'b0 || nm_sel !== 6'b000000) begin errors++; $display("FAIL div_no_m: v=%0b ill=%0b rw=%0b sel=%b want 1/1/0/000000", nm_out_valid, nm_ill, nm_rw, nm_sel); end
        issue(32'h00512423, 32'h110);  // sw x5,8(x2)
        checks++; if (MEM_WRITE !== 1'b1 || REG_WRITE !== 1'b0 || IMMEDIATE !== 32'h8 || OP2_SEL !== 1'b1 || FUNCT3 !== 3'b010) begin errors++; $display("FAIL sw: mw=%0b rw=%0b imm=%h op2=%0b f3=%b want 1/0/8/1/010", MEM_WRITE, REG_WRITE, IMMEDIATE, OP2_SEL, FUNCT3); end
        issue(32'hFE000EE3, 32'h114);  // beq x0,x0,-4
        checks++; if (ALU_SELECT !== 6'b010000 || BRANCH !== 1'b1 || IMMEDIATE !== 32'hFFFFFFFC || REG_WRITE !== 1'b0 || OP2_SEL !== 1'b0) begin errors++; $display("FAIL beq: sel=%b br=%0b imm=%h rw=%0b op2=%0b want 010000/1/fffffffc/0/0", ALU_SELECT, BRANCH, IMMEDIATE, REG_WRITE, OP2_SEL); end
        issue(32'h00002063, 32'h118);  // branch f3=010
        checks++; if (ILLEGAL !== 1'b1 || BRANCH !== 1'b0 || ALU_SELECT !== 6'b000000 || OUT_VALID !== 1'b1) begin errors++; $display("FAIL br_illegal: ill=%0b br=%0b sel=%b v=%0b want 1/0/000000/1", ILLEGAL, BRANCH, ALU_SELECT, OUT_VALID); end
        issue(32'h00000013, 32'h11C);  // addi x0,x0,0
        checks++; if (REG_WRITE !== 1'b0 || ILLEGAL !== 1'b0 || OP2_SEL !== 1'b1) begin errors++; $display("FAIL nop_x0: rw=%0b ill=%0b op2=%0b want 0/0/1", REG_WRITE, ILLEGAL, OP2_SEL); end
        issue(32'h008000EF, 32'h120);  // jal x1,8
        checks++; if (JUMP !== 1'b1 || OP1_SEL !== 1'b1 || IMMEDIATE !== 32'h8 || REG_WRITE !== 1'b1) begin errors++; $display("FAIL jal: j=%0b op1=%0b imm=%h rw=%0b want 1/1/8/1", JUMP, OP1_SEL, IMMEDIATE, REG_WRITE); end
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        OUT_READY = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b1; INSTRUCTION = 32'h002081B3; PC_IN = 32'h300;
        @(negedge CLK);
        checks++; if (OUT_VALID !== 1'b1 || PC_OUT !== 32'h300) begin errors++; $display("FAIL b2b_0: v=%0b pc=%h want 1/300", OUT_VALID, PC_OUT); end
        INSTRUCTION = 32'h40335293; PC_IN = 32'h304;
        @(negedge CLK);
        checks++; if (OUT_VALID !== 1'b1 || PC_OUT !== 32'h304 || ALU_SELECT !== 6'b010101) begin errors++; $display("FAIL b2b_1: v=%0b pc=%h sel=%b want 1/304/010101", OUT_VALID, PC_OUT, ALU_SELECT); end
        INSTRUCTION = 32'h123453B7; PC_IN = 32'h308;
        @(negedge CLK);
        IN_VALID = 1'b0;
        checks++; if (OUT_VALID !== 1'b1 || PC_OUT !== 32'h308 || ALU_SELECT !== 6'b011000) begin errors++; $display("FAIL b2b_2: v=%0b pc=%h sel=%b want 1/308/011000", OUT_VALID, PC_OUT, ALU_SELECT); end
        @(negedge CLK);
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL b2b_end: v=%0b want 0", OUT_VALID); end
    endtask

    task automatic test_skid();
        OUT_READY = 1'b0;
        @(negedge CLK);
        IN_VALID = 1'b1; INSTRUCTION = 32'h002081B3; PC_IN = 32'h200;  // A
        @(negedge CLK);
        checks++; if (OUT_VALID !== 1'b1 || PC_OUT !== 32'h200 || IN_READY !== 1'b1) begin errors++; $display("FAIL skid_a: v=%0b pc=%h rdy=%0b want 1/200/1", OUT_VALID, PC_OUT, IN_READY); end
        INSTRUCTION = 32'h40335293; PC_IN = 32'h204;  // B
        @(negedge CLK);
        checks++; if (IN_READY !== 1'b0 || PC_OUT !== 32'h200) begin errors++; $display("FAIL skid_full: rdy=%0b pc=%h want 0/200", IN_READY, PC_OUT); end
        INSTRUCTION = 32'h123453B7; PC_IN = 32'h208;  // C, held off
        @(negedge CLK);
        checks++; if (IN_READY !== 1'b0 || PC_OUT !== 32'h200 || OUT_VALID !== 1'b1) begin errors++; $display("FAIL skid_hold: rdy=%0b pc=%h v=%0b want 0/200/1", IN_READY, PC_OUT, OUT_VALID); end
        OUT_READY = 1'b1;
        @(negedge CLK);
        checks++; if (PC_OUT !== 32'h204 || ALU_SELECT !== 6'b010101 || IN_READY !== 1'b1) begin errors++; $display("FAIL skid_b: pc=%h sel=%b rdy=%0b want 204/010101/1", PC_OUT, ALU_SELECT, IN_READY); end
        @(negedge CLK);
        IN_VALID = 1'b0;
        checks++; if (PC_OUT !== 32'h208 || ALU_SELECT !== 6'b011000 || OUT_VALID !== 1'b1) begin errors++; $display("FAIL skid_c: pc=%h sel=%b v=%0b want 208/011000/1", PC_OUT, ALU_SELECT, OUT_VALID); end
        @(negedge CLK);
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL skid_end: v=%0b want 0", OUT_VALID); end
    endtask

    task automatic fill_both();
        OUT_READY = 1'b0;
        issue(32'h002081B3, 32'h400);
        issue(32'h40335293, 32'h404);
    endtask

    task automatic test_flush();
        fill_both();
        checks++; if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1) begin errors++; $display("FAIL flush_pre: rdy=%0b v=%0b want 0/1", IN_READY, OUT_VALID); end
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        checks++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin errors++; $display("FAIL flush_clear: v=%0b rdy=%0b want 0/1", OUT_VALID, IN_READY); end
        OUT_READY = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL flush_stale: v=%0b pc=%h want 0", OUT_VALID, PC_OUT); end
        // word accepted in the flush cycle is discarded
        IN_VALID = 1'b1; INSTRUCTION = 32'h123453B7; PC_IN = 32'h408; FLUSH = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b0; FLUSH = 1'b0;
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL flush_discard: v=%0b pc=%h want 0", OUT_VALID, PC_OUT); end
    endtask

    task automatic test_reset_midstream();
        fill_both();
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        checks++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || PC_OUT !== 32'h0) begin errors++; $display("FAIL rst_mid: v=%0b rdy=%0b pc=%h want 0/1/0", OUT_VALID, IN_READY, PC_OUT); end
        OUT_READY = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_mid_stale: v=%0b pc=%h want 0", OUT_VALID, PC_OUT); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_decode();
        test_back_to_back();
        test_skid();
        test_flush();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
